// File: rtl/microseq_next_state.sv
// Microsequencer next-state logic: holds the microstore address and picks the next
// one from encoder dispatch, increment, conditional branch or jump, with a wait-loop timeout.
module microseq_next_state #(
    parameter logic [6:0]  FETCH_STATE = 7'd1,
    parameter logic [6:0]  UNDEF_STATE = 7'd127,
    parameter logic [6:0]  ABORT_STATE = 7'd126,
    parameter int unsigned MAX_WAIT    = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] enc_state,
    input  logic       cond_pass,
    input  logic       moc,
    input  logic [1:0] nsel,
    input  logic [1:0] cond_sel,
    input  logic       inv,
    input  logic [6:0] cr_target,
    output logic [6:0] state,
    output logic       dispatch,
    output logic       timeout
);

    localparam logic [1:0] NSEL_DISPATCH = 2'b00;
    localparam logic [1:0] NSEL_INCR     = 2'b01;
    localparam logic [1:0] NSEL_BRANCH   = 2'b10;
    localparam logic [1:0] NSEL_JUMP     = 2'b11;

    localparam logic [1:0] CSEL_MOC      = 2'd0;
    localparam logic [1:0] CSEL_COND     = 2'd1;
    localparam logic [1:0] CSEL_NMOC     = 2'd2;
    localparam logic [1:0] CSEL_ALWAYS   = 2'd3;

    localparam logic [4:0] WAIT_LAST = 5'(MAX_WAIT - 1);
    localparam logic [4:0] WAIT_SAT  = 5'(MAX_WAIT);

    logic [6:0] state_q, state_d;
    logic       dispatch_q, dispatch_d;
    logic       timeout_q, timeout_d;
    logic [4:0] wait_cnt_q, wait_cnt_d;

    logic       cond_raw;
    logic       cond;
    logic [6:0] state_inc;
    logic [6:0] next_raw;
    logic       dispatch_hit;
    logic       self_loop;
    logic       wait_expire;

    always_comb begin
        cond_raw = 1'b1;
        case (cond_sel)
            CSEL_MOC:    cond_raw = moc;
            CSEL_COND:   cond_raw = cond_pass;
            CSEL_NMOC:   cond_raw = ~moc;
            CSEL_ALWAYS: cond_raw = 1'b1;
            default:     cond_raw = 1'b1;
        endcase
        cond = cond_raw ^ inv;
    end

    always_comb begin
        state_inc    = state_q + 7'd1;
        next_raw     = state_q;
        dispatch_hit = 1'b0;
        case (nsel)
            NSEL_DISPATCH: begin
                if (!cond_pass) begin
                    next_raw = FETCH_STATE;
                end else if (enc_state == 7'd0) begin
                    next_raw = UNDEF_STATE;
                end else begin
                    next_raw     = enc_state;
                    dispatch_hit = 1'b1;
                end
            end
            NSEL_INCR:   next_raw = state_inc;
            NSEL_BRANCH: next_raw = cond ? cr_target : state_inc;
            NSEL_JUMP:   next_raw = cr_target;
            default:     next_raw = state_inc;
        endcase
    end

    // The loop test uses the unoverridden next state, so a dispatch onto the
    // current state also counts toward the timeout; abort beats every source.
    always_comb begin
        self_loop   = (next_raw == state_q);
        wait_expire = self_loop && (wait_cnt_q == WAIT_LAST);
        state_d     = next_raw;
        dispatch_d  = dispatch_hit;
        timeout_d   = 1'b0;
        wait_cnt_d  = '0;
        if (wait_expire) begin
            state_d    = ABORT_STATE;
            dispatch_d = 1'b0;
            timeout_d  = 1'b1;
            wait_cnt_d = '0;
        end else if (self_loop) begin
            wait_cnt_d = (wait_cnt_q == WAIT_SAT) ? WAIT_SAT : wait_cnt_q + 5'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= '0;
            dispatch_q <= 1'b0;
            timeout_q  <= 1'b0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            dispatch_q <= dispatch_d;
            timeout_q  <= timeout_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign state    = state_q;
    assign dispatch = dispatch_q;
    assign timeout  = timeout_q;

endmodule

// File: tb/tb_microseq_next_state.sv
// Directed self-checking bench for microseq_next_state: reset, dispatch, increment,
// conditional branch, wait timeout and reset during a wait loop.
module tb_microseq_next_state;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] enc_state;
    logic       cond_pass;
    logic       moc;
    logic [1:0] nsel;
    logic [1:0] cond_sel;
    logic       inv;
    logic [6:0] cr_target;
    logic [6:0] state;
    logic       dispatch;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    microseq_next_state #(
        .FETCH_STATE(7'd1),
        .UNDEF_STATE(7'd127),
        .ABORT_STATE(7'd126),
        .MAX_WAIT(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enc_state(enc_state),
        .cond_pass(cond_pass),
        .moc(moc),
        .nsel(nsel),
        .cond_sel(cond_sel),
        .inv(inv),
        .cr_target(cr_target),
        .state(state),
        .dispatch(dispatch),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outs(input string tag, input logic [6:0] exp_state,
                            input logic exp_disp, input logic exp_to);
        chk({tag, ".state"}, 32'(state), 32'(exp_state));
        chk({tag, ".dispatch"}, 32'(dispatch), 32'(exp_disp));
        chk({tag, ".timeout"}, 32'(timeout), 32'(exp_to));
    endtask

    task automatic jump(input logic [6:0] target);
        nsel      = 2'b11;
        cr_target = target;
        step();
    endtask

    initial begin
        reset     = 1'b1;
        enc_state = 7'd0;
        cond_pass = 1'b1;
        moc       = 1'b0;
        nsel      = 2'b11;
        cond_sel  = 2'd0;
        inv       = 1'b0;
        cr_target = 7'd1;

        step();
        step();
        chk_outs("reset_hold", 7'd0, 1'b0, 1'b0);
        chk("reset_hold.wait", 32'(dut.wait_cnt_q), 32'd0);
        #3 reset = 1'b0;

        // Leave state 0, then hit reset mid-cycle and expect an immediate clear
        jump(7'd5);
        chk_outs("jump5", 7'd5, 1'b0, 1'b0);
        #3 reset = 1'b1;
        #1 chk_outs("async_reset", 7'd0, 1'b0, 1'b0);
        #1 reset = 1'b0;
        jump(7'd1);
        chk_outs("run_fetch", 7'd1, 1'b0, 1'b0);

        // Dispatch cases
        nsel = 2'b00; enc_state = 7'b0101011; cond_pass = 1'b1;
        step();
        chk_outs("disp43", 7'd43, 1'b1, 1'b0);
        jump(7'd1);
        chk_outs("disp_pulse_end", 7'd1, 1'b0, 1'b0);
        nsel = 2'b00; cond_pass = 1'b0;
        step();
        chk_outs("disp_condfail", 7'd1, 1'b0, 1'b0);
        chk("disp_condfail.wait", 32'(dut.wait_cnt_q), 32'd1);
        enc_state = 7'd0; cond_pass = 1'b1;
        step();
        chk_outs("disp_undef", 7'd127, 1'b0, 1'b0);
        chk("disp_undef.wait", 32'(dut.wait_cnt_q), 32'd0);

        // Increment with 7-bit wrap
        jump(7'd126);
        chk_outs("jump126", 7'd126, 1'b0, 1'b0);
        nsel = 2'b01;
        step();
        chk_outs("inc127", 7'd127, 1'b0, 1'b0);
        step();
        chk_outs("inc_wrap", 7'd0, 1'b0, 1'b0);

        // Branch on ~moc, then on moc^inv: both loop while moc=0
        for (int pass = 0; pass < 2; pass++) begin
            jump(7'd20);
            chk_outs("br_enter", 7'd20, 1'b0, 1'b0);
            nsel = 2'b10; cr_target = 7'd20; moc = 1'b0;
            cond_sel = (pass == 0) ? 2'd2 : 2'd0;
            inv      = (pass == 0) ? 1'b0 : 1'b1;
            for (int k = 1; k <= 3; k++) begin
                step();
                chk_outs("br_wait", 7'd20, 1'b0, 1'b0);
                chk("br_wait.cnt", 32'(dut.wait_cnt_q), 32'(k));
            end
            moc = 1'b1;
            step();
            chk_outs("br_exit", 7'd21, 1'b0, 1'b0);
            chk("br_exit.cnt", 32'(dut.wait_cnt_q), 32'd0);
            moc = 1'b0;
        end

        // Timeout after 16 self-loop edges
        jump(7'd20);
        nsel = 2'b10; cond_sel = 2'd2; inv = 1'b0; cr_target = 7'd20; moc = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            step();
            chk_outs("to_loop", 7'd20, 1'b0, 1'b0);
        end
        step();
        chk_outs("to_fire", 7'd126, 1'b0, 1'b1);
        chk("to_fire.cnt", 32'(dut.wait_cnt_q), 32'd0);
        nsel = 2'b01;
        step();
        chk_outs("to_after", 7'd127, 1'b0, 1'b0);

        // Reset during a wait, then a full 16-cycle loop again
        jump(7'd20);
        nsel = 2'b10; cr_target = 7'd20;
        for (int k = 1; k <= 10; k++) step();
        chk("rw_pre.cnt", 32'(dut.wait_cnt_q), 32'd10);
        #3 reset = 1'b1;
        #1 chk_outs("rw_reset", 7'd0, 1'b0, 1'b0);
        chk("rw_reset.cnt", 32'(dut.wait_cnt_q), 32'd0);
        #1 reset = 1'b0;
        jump(7'd20);
        nsel = 2'b10; cr_target = 7'd20;
        for (int k = 1; k <= 15; k++) begin
            step();
            chk_outs("rw_loop", 7'd20, 1'b0, 1'b0);
        end
        step();
        chk_outs("rw_fire", 7'd126, 1'b0, 1'b1);

        // Repeated dispatch onto the current state: timeout wins over dispatch
        nsel = 2'b00; enc_state = 7'd43; cond_pass = 1'b1;
        step();
        chk_outs("dl_enter", 7'd43, 1'b1, 1'b0);
        for (int k = 1; k <= 15; k++) begin
            step();
            chk_outs("dl_loop", 7'd43, 1'b1, 1'b0);
        end
        step();
        chk_outs("dl_fire", 7'd126, 1'b0, 1'b1);
        jump(7'd1);
        chk_outs("dl_after", 7'd1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
